// File: rtl/fault_mem_pkg.sv
// Shared types for the multi-fault SRAM model: fault codes and slot payload.
// Slot fields are sized for the largest supported memory; users cast down.
package fault_mem_pkg;

    localparam int unsigned SLOT_ADDR_W = 16;
    localparam int unsigned SLOT_BIT_W  = 8;

    typedef enum logic [2:0] {
        FT_NONE  = 3'd0,
        FT_SA0   = 3'd1,
        FT_SA1   = 3'd2,
        FT_TF_UP = 3'd3,
        FT_TF_DN = 3'd4,
        FT_CFID  = 3'd5,
        FT_NPSF  = 3'd6,
        FT_RDF   = 3'd7
    } fault_type_e;

    typedef struct packed {
        fault_type_e            ftype;
        logic [SLOT_ADDR_W-1:0] vaddr;
        logic [SLOT_BIT_W-1:0]  vbit;
        logic [SLOT_ADDR_W-1:0] aaddr;
    } fault_slot_t;

endpackage

// File: rtl/fault_slot_eval.sv
// Evaluates one fault slot against the current access. Produces a force mask
// and force values for the accessed word, and a hit flag (for CFID the hit
// flag means the aggressor transition fired; the caller updates the victim).
module fault_slot_eval
    import fault_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  fault_slot_t             slot_i,
    input  logic                    acc_en_i,
    input  logic                    we_i,
    input  logic [SLOT_ADDR_W-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0]   old_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    nb_prev_i,
    input  logic                    nb_next_i,
    output logic [DATA_WIDTH-1:0]   force_mask_c,
    output logic [DATA_WIDTH-1:0]   force_val_c,
    output logic                    hit_c
);

    logic [DATA_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0] base;
    logic                  victim_match;
    logic                  old_b;
    logic                  new_b;
    logic                  left_b;
    logic                  right_b;
    logic                  cfid_fire;

    // One-hot select of the victim bit; an out-of-range vbit selects nothing.
    always_comb begin
        sel = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            sel[b] = (slot_i.vbit == SLOT_BIT_W'(b));
        end
    end

    assign victim_match = acc_en_i && (addr_i == slot_i.vaddr);
    assign old_b        = |(old_i & sel);
    assign new_b        = |(wdata_i & sel);
    // Shifting the select drops word-edge neighbours, which then read as 0.
    assign left_b       = |(old_i & (sel << 1));
    assign right_b      = |(old_i & (sel >> 1));
    assign base         = we_i ? wdata_i : old_i;

    // Per-type force decision; hit when a forced bit differs from fault-free data.
    always_comb begin
        force_mask_c = '0;
        force_val_c  = '0;
        cfid_fire    = 1'b0;
        case (slot_i.ftype)
            FT_SA0: begin
                if (victim_match) force_mask_c = sel;
            end
            FT_SA1: begin
                if (victim_match) begin
                    force_mask_c = sel;
                    force_val_c  = sel;
                end
            end
            FT_TF_UP: begin
                if (victim_match && we_i && !old_b && new_b) force_mask_c = sel;
            end
            FT_TF_DN: begin
                if (victim_match && we_i && old_b && !new_b) begin
                    force_mask_c = sel;
                    force_val_c  = sel;
                end
            end
            FT_CFID: begin
                cfid_fire = acc_en_i && we_i && (addr_i == slot_i.aaddr) &&
                            (slot_i.aaddr != slot_i.vaddr) && !old_b && new_b;
            end
            FT_NPSF: begin
                if (victim_match && we_i && nb_prev_i && nb_next_i && left_b && right_b) begin
                    force_mask_c = sel;
                    force_val_c  = old_i & sel;
                end
            end
            FT_RDF: begin
                if (victim_match && !we_i) begin
                    force_mask_c = sel;
                    force_val_c  = ~old_i & sel;
                end
            end
            default: ;
        endcase
        hit_c = cfid_fire || (|(force_mask_c & (force_val_c ^ base)));
    end

endmodule

// File: rtl/fault_mem_multi.sv
// Behavioural faulty SRAM with NUM_FAULTS runtime-programmable fault slots.
// Optional statistics (fault_hit / fault_cnt) built when FAULT_MEM_STATS_EN
// is defined; otherwise both outputs are tied to 0.
module fault_mem_multi
    import fault_mem_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned ADDR_WIDTH = 6,
    parameter  int unsigned CAPACITY   = 64,
    parameter  int unsigned NUM_FAULTS = 4,
    localparam int unsigned IDX_W      = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
    localparam int unsigned VB_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  cfg_wr,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [2:0]            cfg_type,
    input  logic [ADDR_WIDTH-1:0] cfg_vaddr,
    input  logic [VB_W-1:0]       cfg_vbit,
    input  logic [ADDR_WIDTH-1:0] cfg_aaddr,
    output logic                  fault_hit,
    output logic [15:0]           fault_cnt
);

    localparam int unsigned    DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned    AE_W    = ADDR_WIDTH + 1;
    localparam logic [AE_W-1:0] CAP_EXT = AE_W'(CAPACITY);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    fault_slot_t           slots_q [NUM_FAULTS];
    fault_slot_t           slots_d [NUM_FAULTS];
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  in_range;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] base_word;
    logic [DATA_WIDTH-1:0] result_word;
    logic [DATA_WIDTH-1:0] force_mask [NUM_FAULTS];
    logic [DATA_WIDTH-1:0] force_val  [NUM_FAULTS];
    logic [NUM_FAULTS-1:0] slot_hit;
    logic [NUM_FAULTS-1:0] cfid_fire;
    logic [ADDR_WIDTH-1:0] victim_addr [NUM_FAULTS];
    logic [VB_W-1:0]       victim_bit  [NUM_FAULTS];

    assign in_range  = {1'b0, address} < CAP_EXT;
    assign old_word  = in_range ? mem_q[address] : '0;
    assign base_word = write_read ? wdata_q : old_word;

    // Per-slot neighbour lookup, evaluation and CFID victim qualification.
    for (genvar i = 0; i < NUM_FAULTS; i++) begin : g_slot
        logic [AE_W-1:0] va_ext;
        logic            prev_ok;
        logic            next_ok;
        logic            nb_prev;
        logic            nb_next;

        assign victim_addr[i] = ADDR_WIDTH'(slots_q[i].vaddr);
        assign victim_bit[i]  = VB_W'(slots_q[i].vbit);
        assign va_ext         = {1'b0, victim_addr[i]};
        assign prev_ok        = (va_ext != '0) && ((va_ext - AE_W'(1)) < CAP_EXT);
        assign next_ok        = (va_ext + AE_W'(1)) < CAP_EXT;
        assign nb_prev        = prev_ok && mem_q[victim_addr[i] - ADDR_WIDTH'(1)][victim_bit[i]];
        assign nb_next        = next_ok && mem_q[victim_addr[i] + ADDR_WIDTH'(1)][victim_bit[i]];
        assign cfid_fire[i]   = slot_hit[i] && (slots_q[i].ftype == FT_CFID) && (va_ext < CAP_EXT);

        fault_slot_eval #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_eval (
            .slot_i       (slots_q[i]),
            .acc_en_i     (in_range),
            .we_i         (write_read),
            .addr_i       (SLOT_ADDR_W'(address)),
            .old_i        (old_word),
            .wdata_i      (wdata_q),
            .nb_prev_i    (nb_prev),
            .nb_next_i    (nb_next),
            .force_mask_c (force_mask[i]),
            .force_val_c  (force_val[i]),
            .hit_c        (slot_hit[i])
        );
    end

    // Merge slot forces in ascending index so the highest slot wins a shared bit.
    always_comb begin
        result_word = base_word;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            result_word = (result_word & ~force_mask[i]) | (force_mask[i] & force_val[i]);
        end
    end

    // Slot programming; the new slot is visible from the next cycle.
    always_comb begin
        for (int i = 0; i < NUM_FAULTS; i++) begin
            slots_d[i] = slots_q[i];
            if (cfg_wr && (cfg_idx == IDX_W'(i))) begin
                slots_d[i].ftype = fault_type_e'(cfg_type);
                slots_d[i].vaddr = SLOT_ADDR_W'(cfg_vaddr);
                slots_d[i].vbit  = SLOT_BIT_W'(cfg_vbit);
                slots_d[i].aaddr = SLOT_ADDR_W'(cfg_aaddr);
            end
        end
    end

    // Write-data stage, two-stage read pipeline and slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            for (int i = 0; i < NUM_FAULTS; i++) begin
                slots_q[i] <= '{ftype: FT_NONE, vaddr: '0, vbit: '0, aaddr: '0};
            end
        end else begin
            wdata_q <= wdata;
            if (!write_read) rd_q <= result_word;
            rdata_q <= rd_q;
            for (int i = 0; i < NUM_FAULTS; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    assign rdata = rdata_q;

    // Array update: faulted write data, read write-back (RDF/SA) and CFID victims.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (in_range && (write_read || (result_word != old_word))) begin
                mem_q[address] <= result_word;
            end
            for (int i = 0; i < NUM_FAULTS; i++) begin
                if (cfid_fire[i]) mem_q[victim_addr[i]][victim_bit[i]] <= 1'b1;
            end
        end
    end

`ifdef FAULT_MEM_STATS_EN
    logic [NUM_FAULTS-1:0] cfid_change;
    logic                  acc_fault_c;
    logic                  fault_hit_q;
    logic [15:0]           fault_cnt_q;

    // A CFID only alters the array when the victim bit was still 0.
    for (genvar i = 0; i < NUM_FAULTS; i++) begin : g_cfid_chg
        assign cfid_change[i] = cfid_fire[i] && !mem_q[victim_addr[i]][victim_bit[i]];
    end

    assign acc_fault_c = (result_word != base_word) || (|cfid_change);

    // One-cycle hit pulse and saturating activation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_hit_q <= 1'b0;
            fault_cnt_q <= '0;
        end else begin
            fault_hit_q <= acc_fault_c;
            if (acc_fault_c && (fault_cnt_q != 16'hFFFF)) fault_cnt_q <= fault_cnt_q + 16'd1;
        end
    end

    assign fault_hit = fault_hit_q;
    assign fault_cnt = fault_cnt_q;
`else
    assign fault_hit = 1'b0;
    assign fault_cnt = '0;
`endif

endmodule

// File: tb/tb_fault_mem_multi.sv
// Directed bench for fault_mem_multi (default parameters). Statistics outputs
// are expected live only when FAULT_MEM_STATS_EN is defined.
module tb_fault_mem_multi;

`ifdef FAULT_MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [5:0] IDLE = 6'd62;

    logic       clk = 1'b0;
    logic       rst;
    logic       write_read;
    logic [5:0] address;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       cfg_wr;
    logic [1:0] cfg_idx;
    logic [2:0] cfg_type;
    logic [5:0] cfg_vaddr;
    logic [2:0] cfg_vbit;
    logic [5:0] cfg_aaddr;
    logic       fault_hit;
    logic [15:0] fault_cnt;

    int errors = 0;
    int checks = 0;

    fault_mem_multi dut (
        .clk        (clk),
        .rst        (rst),
        .write_read (write_read),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .cfg_wr     (cfg_wr),
        .cfg_idx    (cfg_idx),
        .cfg_type   (cfg_type),
        .cfg_vaddr  (cfg_vaddr),
        .cfg_vbit   (cfg_vbit),
        .cfg_aaddr  (cfg_aaddr),
        .fault_hit  (fault_hit),
        .fault_cnt  (fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic we, input logic [5:0] a, input logic [7:0] d);
        write_read = we;
        address    = a;
        wdata      = d;
        @(negedge clk);
    endtask

    // wdata is presented one cycle ahead of the write (idle read in between).
    task automatic do_write(input logic [5:0] a, input logic [7:0] d);
        cycle(1'b0, IDLE, d);
        cycle(1'b1, a, d);
    endtask

    task automatic do_read(input logic [5:0] a, output logic [7:0] q);
        cycle(1'b0, a, 8'h00);
        cycle(1'b0, IDLE, 8'h00);
        q = rdata;
    endtask

    task automatic set_slot(input logic [1:0] idx, input logic [2:0] ty,
                            input logic [5:0] va, input logic [2:0] vb, input logic [5:0] aa);
        cfg_wr    = 1'b1;
        cfg_idx   = idx;
        cfg_type  = ty;
        cfg_vaddr = va;
        cfg_vbit  = vb;
        cfg_aaddr = aa;
        cycle(1'b0, IDLE, 8'h00);
        cfg_wr    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_wr = 1'b0; cfg_idx = '0; cfg_type = '0;
        cfg_vaddr = '0; cfg_vbit = '0; cfg_aaddr = '0;
        write_read = 1'b0; address = IDLE; wdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        checks++; if (fault_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", fault_hit); end
        checks++; if (fault_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", fault_cnt); end
    endtask

    task automatic test_basic();
        logic [7:0] q;
        do_write(6'd3, 8'hA5);
        checks++; if (fault_hit !== 1'b0) begin errors++; $display("FAIL basic_hit: got %b expected 0", fault_hit); end
        do_read(6'd3, q);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL basic_read: got %h expected a5", q); end
        do_write(6'd63, 8'h3C);
        do_write(6'd0, 8'h5A);
        do_read(6'd63, q);
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL top_addr_read: got %h expected 3c", q); end
        do_read(6'd0, q);
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL addr0_read: got %h expected 5a", q); end
    endtask

    task automatic test_sa1();
        logic [7:0] q;
        set_slot(2'd0, 3'd2, 6'd5, 3'd2, 6'd0);
        do_write(6'd5, 8'h00);
        checks++; if (fault_hit !== STATS) begin errors++; $display("FAIL sa1_hit: got %b expected %b", fault_hit, STATS); end
        do_read(6'd5, q);
        checks++; if (q !== 8'h04) begin errors++; $display("FAIL sa1_read: got %h expected 04", q); end
        checks++; if (fault_hit !== 1'b0) begin errors++; $display("FAIL sa1_hit_once: got %b expected 0", fault_hit); end
        checks++; if (fault_cnt !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL sa1_cnt: got %0d expected %0d", fault_cnt, STATS ? 1 : 0); end
    endtask

    task automatic test_tf_up();
        logic [7:0] q;
        set_slot(2'd1, 3'd3, 6'd7, 3'd0, 6'd0);
        do_write(6'd7, 8'h00);
        do_write(6'd7, 8'hFF);
        do_read(6'd7, q);
        checks++; if (q !== 8'hFE) begin errors++; $display("FAIL tf_up_read: got %h expected fe", q); end
        do_write(6'd7, 8'h00);
        do_read(6'd7, q);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL tf_up_clear: got %h expected 00", q); end
        checks++; if (fault_cnt !== (STATS ? 16'd2 : 16'd0)) begin errors++; $display("FAIL tf_up_cnt: got %0d expected %0d", fault_cnt, STATS ? 2 : 0); end
    endtask

    task automatic test_cfid();
        logic [7:0] q;
        set_slot(2'd2, 3'd5, 6'd11, 3'd4, 6'd10);
        do_write(6'd10, 8'h00);
        do_write(6'd11, 8'h00);
        do_write(6'd10, 8'h10);
        do_read(6'd11, q);
        checks++; if (q !== 8'h10) begin errors++; $display("FAIL cfid_victim: got %h expected 10", q); end
        do_read(6'd10, q);
        checks++; if (q !== 8'h10) begin errors++; $display("FAIL cfid_aggr: got %h expected 10", q); end
        checks++; if (fault_cnt !== (STATS ? 16'd3 : 16'd0)) begin errors++; $display("FAIL cfid_cnt: got %0d expected %0d", fault_cnt, STATS ? 3 : 0); end
    endtask

    task automatic test_npsf();
        logic [7:0] q;
        set_slot(2'd3, 3'd6, 6'd20, 3'd1, 6'd0);
        do_write(6'd21, 8'h00);
        do_write(6'd19, 8'h02);
        do_write(6'd20, 8'h07);
        do_write(6'd21, 8'h02);
        do_write(6'd20, 8'h05);
        checks++; if (fault_hit !== STATS) begin errors++; $display("FAIL npsf_hit: got %b expected %b", fault_hit, STATS); end
        do_read(6'd20, q);
        checks++; if (q !== 8'h07) begin errors++; $display("FAIL npsf_read: got %h expected 07", q); end
        do_write(6'd21, 8'h00);
        do_write(6'd20, 8'h05);
        do_read(6'd20, q);
        checks++; if (q !== 8'h05) begin errors++; $display("FAIL npsf_open: got %h expected 05", q); end
        checks++; if (fault_cnt !== (STATS ? 16'd4 : 16'd0)) begin errors++; $display("FAIL npsf_cnt: got %0d expected %0d", fault_cnt, STATS ? 4 : 0); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] q;
        cycle(1'b0, 6'd20, 8'h00);
        rst = 1'b1;
        cycle(1'b0, IDLE, 8'h00);
        rst = 1'b0;
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL midrd_rdata: got %h expected 00", rdata); end
        checks++; if (fault_cnt !== 16'd0) begin errors++; $display("FAIL midrd_cnt: got %0d expected 0", fault_cnt); end
        checks++; if (fault_hit !== 1'b0) begin errors++; $display("FAIL midrd_hit: got %b expected 0", fault_hit); end
        do_write(6'd5, 8'h00);
        do_read(6'd5, q);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL sa1_cleared: got %h expected 00", q); end
        do_write(6'd7, 8'h00);
        do_write(6'd7, 8'hFF);
        do_read(6'd7, q);
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL tf_cleared: got %h expected ff", q); end
        checks++; if (fault_cnt !== 16'd0) begin errors++; $display("FAIL cleared_cnt: got %0d expected 0", fault_cnt); end
    endtask

    task automatic test_priority_rdf();
        logic [7:0] q;
        set_slot(2'd0, 3'd1, 6'd30, 3'd3, 6'd0);
        set_slot(2'd1, 3'd2, 6'd30, 3'd3, 6'd0);
        do_write(6'd30, 8'h00);
        do_read(6'd30, q);
        checks++; if (q !== 8'h08) begin errors++; $display("FAIL prio_high_wins: got %h expected 08", q); end
        set_slot(2'd1, 3'd0, 6'd0, 3'd0, 6'd0);
        do_write(6'd30, 8'h08);
        do_read(6'd30, q);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL prio_sa0: got %h expected 00", q); end
        set_slot(2'd2, 3'd5, 6'd40, 3'd0, 6'd40);
        do_write(6'd40, 8'h00);
        do_write(6'd40, 8'h01);
        do_read(6'd40, q);
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL cfid_self: got %h expected 01", q); end
        set_slot(2'd3, 3'd7, 6'd50, 3'd7, 6'd0);
        do_write(6'd50, 8'h81);
        do_read(6'd50, q);
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL rdf_first: got %h expected 01", q); end
        do_read(6'd50, q);
        checks++; if (q !== 8'h81) begin errors++; $display("FAIL rdf_second: got %h expected 81", q); end
        checks++; if (fault_cnt !== (STATS ? 16'd4 : 16'd0)) begin errors++; $display("FAIL prio_rdf_cnt: got %0d expected %0d", fault_cnt, STATS ? 4 : 0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sa1();
        test_tf_up();
        test_cfid();
        test_npsf();
        test_reset_mid_read();
        test_priority_rdf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
